// File: rtl/tx_len_tagger.sv
// Store-and-forward length tagger placed ahead of the DoCE transmit FSM.
// Each packet is replayed with tuser = {byte_len, chan} valid from its first beat.
module tx_len_tagger #(
   parameter int DATA_DEPTH = 512,
   parameter int LEN_DEPTH  = 16,
   parameter int MAX_BEATS  = 512
) (
   input  logic         user_clk,
   input  logic         reset,
   input  logic [127:0] s_axis_tdata,
   input  logic [15:0]  s_axis_tkeep,
   input  logic         s_axis_tvalid,
   input  logic         s_axis_tlast,
   input  logic [3:0]   s_axis_tuser,
   output logic         s_axis_tready,
   output logic [127:0] m_axis_tdata,
   output logic [15:0]  m_axis_tkeep,
   output logic         m_axis_tvalid,
   output logic         m_axis_tlast,
   output logic [16:0]  m_axis_tuser,
   input  logic         m_axis_tready,
   output logic         err_trunc,
   output logic [15:0]  pkt_count
);

   localparam int DAW = $clog2(DATA_DEPTH);
   localparam int LAW = $clog2(LEN_DEPTH);
   localparam int BW  = $clog2(MAX_BEATS + 1);
   localparam int DW  = 1 + 16 + 128;
   localparam int LW  = 17;

   localparam logic [BW-1:0] MAX_B = BW'(MAX_BEATS);
   localparam logic [14:0]   SAT   = 15'd8191;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      DISCARD
   } in_state_e;

   function automatic logic [4:0] popcnt16(input logic [15:0] k);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, k[i]};
      end
      return c;
   endfunction

   logic [DW-1:0] data_mem [DATA_DEPTH];
   logic [LW-1:0] len_mem  [LEN_DEPTH];

   in_state_e     state_q, state_d;
   logic [BW-1:0] beats_q, beats_d;
   logic [13:0]   bytes_q, bytes_d;
   logic [3:0]    chan_q, chan_d;
   logic          err_trunc_q, err_trunc_d;

   logic [DAW:0]  dwp_q, dwp_d;
   logic [DAW:0]  drp_q, drp_d;
   logic [LAW:0]  lwp_q, lwp_d;
   logic [LAW:0]  lrp_q, lrp_d;
   logic [LAW:0]  lld_q, lld_d;

   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic [127:0]  out_data_q, out_data_d;
   logic [15:0]   out_keep_q, out_keep_d;
   logic [16:0]   out_user_q, out_user_d;
   logic [15:0]   pkt_cnt_q, pkt_cnt_d;

   logic          data_full;
   logic          len_full;
   logic          s_ready;
   logic          acc;
   logic          wr_en;
   logic          wr_last;
   logic          push;
   logic          trunc;
   logic          at_max;
   logic [4:0]    in_pc;
   logic [BW-1:0] beat_num;
   logic [13:0]   base;
   logic [14:0]   sum;
   logic [13:0]   byte_new;
   logic [3:0]    chan_new;

   logic          desc_avail;
   logic          out_free;
   logic          load;
   logic          hs;
   logic          pop;
   logic [DW-1:0] rd_word;

   always_comb begin
      data_full = (dwp_q[DAW] != drp_q[DAW]) &&
                  (dwp_q[DAW-1:0] == drp_q[DAW-1:0]);
      len_full  = (lwp_q[LAW] != lrp_q[LAW]) &&
                  (lwp_q[LAW-1:0] == lrp_q[LAW-1:0]);
      s_ready   = !reset &&
                  ((state_q == DISCARD) || (!data_full && !len_full));
      acc       = s_axis_tvalid && s_ready;

      in_pc    = popcnt16(s_axis_tkeep);
      beat_num = (state_q == IDLE) ? BW'(1) : beats_q + BW'(1);
      at_max   = (beat_num == MAX_B);
      base     = (state_q == IDLE) ? 14'd0 : bytes_q;
      // Saturate every step; the sum only grows, so this equals a final clamp.
      sum      = {1'b0, base} + {10'd0, in_pc};
      byte_new = (sum > SAT) ? 14'd8191 : sum[13:0];
      chan_new = (state_q == IDLE) ? s_axis_tuser : chan_q;

      wr_en   = acc && (state_q != DISCARD);
      wr_last = s_axis_tlast || at_max;
      push    = wr_en && wr_last;
      trunc   = wr_en && at_max && !s_axis_tlast;
   end

   always_comb begin
      state_d     = state_q;
      beats_d     = beats_q;
      bytes_d     = bytes_q;
      chan_d      = chan_q;
      err_trunc_d = trunc;
      dwp_d       = dwp_q + {{DAW{1'b0}}, wr_en};
      lwp_d       = lwp_q + {{LAW{1'b0}}, push};

      unique case (state_q)
         IDLE: begin
            if (acc) begin
               chan_d  = s_axis_tuser;
               beats_d = BW'(1);
               bytes_d = byte_new;
               if (trunc) begin
                  state_d = DISCARD;
               end else if (!s_axis_tlast) begin
                  state_d = ACCEPT;
               end
            end
         end
         ACCEPT: begin
            if (acc) begin
               beats_d = beat_num;
               bytes_d = byte_new;
               if (trunc) begin
                  state_d = DISCARD;
               end else if (s_axis_tlast) begin
                  state_d = IDLE;
               end
            end
         end
         DISCARD: begin
            if (acc && s_axis_tlast) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // lld runs ahead of lrp: it marks descriptors already handed to the
   // output register, while lrp frees the slot only on the tlast handshake.
   always_comb begin
      desc_avail = (lld_q != lwp_q);
      out_free   = !out_valid_q || m_axis_tready;
      load       = out_free && desc_avail;
      hs         = out_valid_q && m_axis_tready;
      pop        = hs && out_last_q;
      rd_word    = data_mem[drp_q[DAW-1:0]];

      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_user_d  = out_user_q;
      drp_d       = drp_q;
      lld_d       = lld_q;

      if (load) begin
         out_valid_d = 1'b1;
         out_last_d  = rd_word[DW-1];
         out_keep_d  = rd_word[143:128];
         out_data_d  = rd_word[127:0];
         out_user_d  = len_mem[lld_q[LAW-1:0]];
         drp_d       = drp_q + {{DAW{1'b0}}, 1'b1};
         lld_d       = lld_q + {{LAW{1'b0}}, rd_word[DW-1]};
      end else if (hs) begin
         out_valid_d = 1'b0;
      end

      lrp_d     = lrp_q + {{LAW{1'b0}}, pop};
      pkt_cnt_d = pkt_cnt_q + {15'd0, pop};
   end

   always_ff @(posedge user_clk) begin
      if (reset) begin
         state_q     <= IDLE;
         beats_q     <= '0;
         bytes_q     <= '0;
         chan_q      <= '0;
         err_trunc_q <= 1'b0;
         dwp_q       <= '0;
         drp_q       <= '0;
         lwp_q       <= '0;
         lrp_q       <= '0;
         lld_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_user_q  <= '0;
         pkt_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         bytes_q     <= bytes_d;
         chan_q      <= chan_d;
         err_trunc_q <= err_trunc_d;
         dwp_q       <= dwp_d;
         drp_q       <= drp_d;
         lwp_q       <= lwp_d;
         lrp_q       <= lrp_d;
         lld_q       <= lld_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_user_q  <= out_user_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   always_ff @(posedge user_clk) begin
      if (wr_en) begin
         data_mem[dwp_q[DAW-1:0]] <= {wr_last, s_axis_tkeep, s_axis_tdata};
      end
      if (push) begin
         len_mem[lwp_q[LAW-1:0]] <= {byte_new[12:0], chan_new};
      end
   end

   assign s_axis_tready = s_ready;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tuser  = out_user_q;
   assign err_trunc     = err_trunc_q;
   assign pkt_count     = pkt_cnt_q;

endmodule

// File: doc/tx_len_tagger.md
Name: tx_len_tagger

Overview:
Store-and-forward stage directly upstream of the DoCE transmit FSM. It buffers each outgoing transport-layer packet, counts its byte length, then replays it with tuser = {byte_len[12:0], chan[3:0]} valid and stable from the first beat. This gives the downstream MAC-header builder the frame length at packet start.

Parameters:
DATA_DEPTH, 512, data buffer depth in 128-bit beats; power of 2, ≥ MAX_BEATS.
LEN_DEPTH, 16, length/descriptor FIFO depth in packets; power of 2.
MAX_BEATS, 512, maximum beats per packet; longer packets are truncated.

Ports:
user_clk  in  1  clock
reset  in  1  synchronous, active-high
s_axis_tdata  in  128  payload from transport engine
s_axis_tkeep  in  16  byte enables
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  last beat of packet
s_axis_tuser  in  4  channel id, sampled on the first beat
s_axis_tready  out  1  input ready
m_axis_tdata  out  128  to transmit FSM
m_axis_tkeep  out  16  to transmit FSM
m_axis_tvalid  out  1  to transmit FSM
m_axis_tlast  out  1  to transmit FSM
m_axis_tuser  out  17  {byte_len[12:0], chan[3:0]}
m_axis_tready  in  1  from transmit FSM
err_trunc  out  1  one-cycle pulse: a packet was truncated
pkt_count  out  16  packets emitted (tlast handshakes on m_axis), wraps at 0xFFFF→0

Behaviour:
- Reset (reset=1 on a user_clk edge): both FIFOs empty, input FSM = IDLE, beat/byte counters 0. Outputs: m_axis_tvalid=0, s_axis_tready=0 during reset and 1 in the first cycle after, err_trunc=0, pkt_count=0, m_axis_tdata/tkeep/tuser=0, m_axis_tlast=0. Reset mid-packet discards all buffered and partial data with no output.
- Keep rule: non-last beats carry tkeep=16'hFFFF. Last-beat tkeep is contiguous and low-aligned. byte_len = 16*(beats-1) + popcount(last tkeep). byte_len is computed at 14 bits internally and saturates at 8191 before truncation to 13 bits. A last beat with tkeep=0 contributes 0 bytes.
- s_axis_tready = !data_full && !len_full, or 1 in DISCARD. Accept = tvalid && tready.
- Input FSM:
  - IDLE: on accept, latch chan=s_axis_tuser, write beat, beats=1, bytes=popcount. With tlast → push descriptor, stay IDLE. Otherwise → ACCEPT.
  - ACCEPT: each accept writes the beat and increments counters. On tlast → push descriptor, go IDLE. If the beat is number MAX_BEATS and has no tlast → write it with tlast forced to 1, push descriptor (byte_len computed from the beats kept), pulse err_trunc, go DISCARD.
  - DISCARD: tready=1. Beats are accepted and dropped. On tlast → IDLE.
- Descriptor push and data write of the last beat happen in the same cycle. The descriptor becomes visible to the read side in the next cycle.
- Read side:
  - Registered output stage. m_axis_tvalid asserts only when the descriptor FIFO is non-empty; no beats of an incomplete packet are emitted.
  - Latency: an input tlast accepted in cycle T gives the first m_axis_tvalid no earlier than T+2, and exactly T+2 when the output is idle.
  - Output beats are back-to-back while m_axis_tready=1.
  - m_axis_tuser is held constant on every beat of a packet.
  - The descriptor is popped on the m_axis tlast handshake.
  - Output holds tdata/tkeep/tlast/tuser/tvalid stable while tvalid && !tready.
- Simultaneous push/pop on either FIFO in one cycle is legal; occupancy is unchanged. Full flags use an extra wrap bit on the pointers; no overflow or underflow ever occurs.
- pkt_count increments on each m_axis tlast handshake.

Test Plan:
- Single 3-beat packet, chan=4'h5, last tkeep=16'h00FF, m_axis_tready=1 → 3 output beats; tuser={13'd40,4'h5} on all three; first tvalid 2 cycles after input tlast; pkt_count=1.
- 1-beat packet, tkeep=16'h0001, then 1-beat packet with tkeep=0 → tuser lengths 1 and 0; both emitted in order.
- m_axis_tready toggled 1/0 each cycle over a 10-beat packet → no beat lost or duplicated; output stable during stalls; tuser=160 throughout.
- Hold m_axis_tready=0 and stream 16 one-beat packets with LEN_DEPTH=16 → s_axis_tready drops after the 16th. Release → all 16 emitted; tready returns.
- 600-beat packet with MAX_BEATS=512 → output of 512 beats with tlast on beat 512, tuser length 8191 (saturated); err_trunc pulses once; beats 513..600 accepted and dropped. The next packet is unaffected.
- Assert reset mid-packet after 5 input beats → no output, tvalid=0, pkt_count=0. A new packet after reset is emitted correctly.
